seg7_scan: RTL and testbench

//  Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_scan_if.sv | 12 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan.sv | 80 ++++++++
 tb/tb_seg7_scan.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment map for the 7-segment display blocks.
// Pure definitions: no latency, no flow control.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Core-to-display bundle: display word and page select in, digit/segment drive and frame pulse out.
// No handshake; the display side samples data_seg/page once per frame.
interface seg7_scan_if;
  logic [31:0] data_seg;
  logic        page;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_tick;

  modport master (output data_seg, output page, input anode, input seg, input frame_tick);
  modport slave  (input data_seg, input page, output anode, output seg, output frame_tick);
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low segment decoder (gfedcba); zero latency, no backpressure.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex2seg(nib);

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-seg driver; anode/seg registered 1 cycle after (div_cnt, dig, snap), no backpressure.
// Optional leading-zero suppression under `define SEG7_LZ_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
)(
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);

  localparam int             CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  digit_idx_t       dig;
  logic [15:0]      snap;
  logic [3:0]       anode_q;
  logic [6:0]       seg_q;

  logic             slot_end;
  logic             capture;
  logic             in_blank;
  logic             digit_on;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_seg;

  assign slot_end = (div_cnt == CNT_MAX);
  assign capture  = slot_end && (dig == 2'd3);
  assign in_blank = (BLANK_CYC > 0) && (int'(div_cnt) < BLANK_CYC);
  assign cur_nib  = snap[{dig, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // Highest non-zero nibble; digit 0 stays lit so an all-zero word shows a single 0.
  digit_idx_t msd;
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (snap[4*i +: 4] != 4'h0) msd = digit_idx_t'(i);
    end
  end
  assign digit_on = (dig <= msd);
`else
  assign digit_on = 1'b1;
`endif

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      dig     <= '0;
      snap    <= '0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) dig <= dig + 2'd1;
      // Snapshot only at frame end so a changing word never tears across digits.
      if (capture) snap <= bus.page ? bus.data_seg[31:16] : bus.data_seg[15:0];
      if (in_blank) begin
        anode_q <= ANODE_OFF;
        seg_q   <= SEG_OFF;
      end else begin
        anode_q <= digit_on ? ~(4'b0001 << dig) : ANODE_OFF;
        seg_q   <= cur_seg;
      end
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = capture && !rst;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with SCAN_DIV=8, BLANK_CYC=2: table of frames checked slot by slot,
// plus a cycle scoreboard, reset-mid-slot and per-cycle data churn sequences.
module tb_seg7_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seg7_scan_if sif ();

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef SEG7_LZ_BLANK_EN
  function automatic int msd_of(input logic [15:0] v);
    int m;
    m = 0;
    for (int i = 1; i < 4; i++) if (v[4*i +: 4] != 4'h0) m = i;
    return m;
  endfunction
`endif

  // ---------------- cycle scoreboard ----------------
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
  } out_t;

  out_t        q[$];
  out_t        e_out;
  int          m_cnt = 0;
  int          m_dig = 0;
  logic [15:0] m_snap = 16'h0;
  int          cyc = 0;
  int          last_ft = -1;

  function automatic out_t model_out();
    out_t o;
    logic [3:0] nib;
    nib = m_snap[4*m_dig +: 4];
    if (m_cnt < BC) begin
      o.an = 4'hF;
      o.sg = 7'h7F;
    end else begin
      o.an = ~(4'b0001 << m_dig);
`ifdef SEG7_LZ_BLANK_EN
      if (m_dig > msd_of(m_snap)) o.an = 4'hF;
`endif
      o.sg = seg_tab[nib];
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.push_back('{an: 4'hF, sg: 7'h7F});
      m_cnt  = 0;
      m_dig  = 0;
      m_snap = 16'h0;
    end else begin
      q.push_back(model_out());
      if (m_cnt == SD - 1) begin
        if (m_dig == 3) m_snap = sif.page ? sif.data_seg[31:16] : sif.data_seg[15:0];
        m_dig = (m_dig + 1) % 4;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      e_out = q.pop_front();
      check("sb_anode", sif.anode, e_out.an);
      check("sb_seg", sif.seg, e_out.sg);
      check("sb_onehot", ($countones(~sif.anode) <= 1), 1'b1);
      check("sb_tick", sif.frame_tick, (m_cnt == SD - 1) && (m_dig == 3) && !rst);
    end
    if (rst) begin
      last_ft = -1;
    end else if (sif.frame_tick) begin
      if (last_ft >= 0) check("tick_period", cyc - last_ft, 4 * SD);
      last_ft = cyc;
    end
  end

  // ---------------- frame window check ----------------
  // Window cycle j shows the register loaded from div_cnt=j%8, dig=j/8 of one frame.
  task automatic run_window(input logic [15:0] exp, input logic [31:0] nd, input logic np,
                            input bit churn);
    int         d;
    bit         blank;
    bit         lit;
    logic [3:0] ea;
    logic [6:0] es;
    for (int j = 0; j < 4 * SD; j++) begin
      d     = j / SD;
      blank = (j % SD) < BC;
      lit   = !blank;
`ifdef SEG7_LZ_BLANK_EN
      if (d > msd_of(exp)) lit = 1'b0;
`endif
      ea = lit ? ~(4'b0001 << d) : 4'hF;
      es = blank ? 7'h7F : seg_tab[exp[4*d +: 4]];
      @(negedge clk);
      check("win_anode", sif.anode, ea);
      check("win_seg", sif.seg, es);
      check("win_tick", sif.frame_tick, (j == 4 * SD - 2));
      if (churn) begin
        @(posedge clk);
        #2;
        // Only the value held in the capture cycle may reach the display.
        if (j == 4 * SD - 3) begin
          sif.data_seg = nd;
          sif.page     = np;
        end else begin
          sif.data_seg = $urandom;
          sif.page     = 1'($urandom_range(0, 1));
        end
      end else if (j == 15) begin
        @(posedge clk);
        #2;
        sif.data_seg = nd;
        sif.page     = np;
      end
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        page;
    logic [15:0] exp;
    bit          churn;
  } vec_t;

  vec_t tab [5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx;
    tab[0] = '{32'h0000_1234, 1'b0, 16'h1234, 1'b0};
    tab[1] = '{32'hABCD_0F18, 1'b1, 16'hABCD, 1'b0};
    tab[2] = '{32'hABCD_0F18, 1'b0, 16'h0F18, 1'b0};
    tab[3] = '{32'hFFFF_5678, 1'b0, 16'h5678, 1'b1};
    tab[4] = '{32'h9E0C_0000, 1'b1, 16'h9E0C, 1'b0};

    sif.data_seg = tab[0].data;
    sif.page     = tab[0].page;
    rst          = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_anode", sif.anode, 4'hF);
      check("rst_seg", sif.seg, 7'h7F);
      check("rst_tick", sif.frame_tick, 1'b0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    run_window(16'h0000, tab[0].data, tab[0].page, 1'b0);

    for (int i = 0; i < 5; i++) begin
      nx = (i < 4) ? i + 1 : i;
      run_window(tab[i].exp, tab[nx].data, tab[nx].page, tab[nx].churn);
    end

    // Reset mid-slot with dig=2, div_cnt=4.
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_anode", sif.anode, 4'hF);
    check("midrst_seg", sif.seg, 7'h7F);
    check("midrst_tick", sif.frame_tick, 1'b0);
    @(posedge clk);
    #2;
    rst          = 1'b0;
    sif.data_seg = 32'h0000_0005;
    sif.page     = 1'b0;
    @(negedge clk);
    run_window(16'h0000, 32'h0000_0005, 1'b0, 1'b0);
    run_window(16'h0005, 32'h0000_0000, 1'b0, 1'b0);
    run_window(16'h0000, 32'h0000_0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
